// File: rtl/tdm_demux4_if.sv
// rtl/tdm_demux4_if.sv - serial TDM stream in, reassembled four-channel frame out
interface tdm_demux4_if;
  logic       din;
  logic       din_valid;
  logic       frame_sync;
  logic       out0;
  logic       out1;
  logic       out2;
  logic       out3;
  logic       frame_valid;
  logic [1:0] slot;
  logic       locked;
  logic       sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  out0, out1, out2, out3, frame_valid, slot, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output out0, out1, out2, out3, frame_valid, slot, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - four-slot TDM demultiplexer with frame-sync lock tracking
module tdm_demux4 #(
  parameter int SYNC_LOSS_LIMIT = 3
) (
  input logic         clk,
  input logic         rst_n,
  tdm_demux4_if.slave bus
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t     state_q, state_d;
  logic [1:0] slot_q, slot_d;
  logic [3:0] miss_q, miss_d;
  logic [2:0] shadow_q, shadow_d;
  logic [3:0] out_q, out_d;
  logic       frame_valid_q, frame_valid_d;
  logic       sync_err_q, sync_err_d;
  logic       locked_q;
  logic [3:0] miss_inc;

  assign miss_inc = miss_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      slot_q        <= 2'd0;
      miss_q        <= 4'd0;
      shadow_q      <= 3'd0;
      out_q         <= 4'd0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      miss_q        <= miss_d;
      shadow_q      <= shadow_d;
      out_q         <= out_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      locked_q      <= (state_d == LOCKED);
    end
  end

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    miss_d        = miss_q;
    shadow_d      = shadow_q;
    out_d         = out_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    if (bus.din_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.frame_sync) begin
            shadow_d[0] = bus.din;
            slot_d      = 2'd1;
            miss_d      = 4'd0;
            state_d     = LOCKED;
          end
        end
        default: begin
          if (slot_q == 2'd0) begin
            if (bus.frame_sync) begin
              shadow_d[0] = bus.din;
              slot_d      = 2'd1;
              miss_d      = 4'd0;
            end else if (miss_inc == 4'(SYNC_LOSS_LIMIT)) begin
              // Lock lost: this beat is dropped rather than starting a frame.
              state_d = HUNT;
              slot_d  = 2'd0;
              miss_d  = 4'd0;
            end else begin
              shadow_d[0] = bus.din;
              slot_d      = 2'd1;
              miss_d      = miss_inc;
            end
          end else if (bus.frame_sync) begin
            // Misaligned sync restarts the frame from this beat.
            sync_err_d  = 1'b1;
            shadow_d[0] = bus.din;
            slot_d      = 2'd1;
            miss_d      = 4'd0;
          end else if (slot_q == 2'd3) begin
            out_d         = {bus.din, shadow_q};
            frame_valid_d = 1'b1;
            slot_d        = 2'd0;
          end else begin
            if (slot_q == 2'd1) shadow_d[1] = bus.din;
            else                shadow_d[2] = bus.din;
            slot_d = slot_q + 2'd1;
          end
        end
      endcase
    end
  end

  assign bus.out0        = out_q[0];
  assign bus.out1        = out_q[1];
  assign bus.out2        = out_q[2];
  assign bus.out3        = out_q[3];
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.slot        = slot_q;
  assign bus.locked      = locked_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - directed vector bench for tdm_demux4
module tb_tdm_demux4;

  typedef struct {
    logic       dv;
    logic       fs;
    logic       d;
    logic [3:0] out;
    logic       fv;
    logic       se;
    logic       lk;
    logic [1:0] slot;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl[$];

  tdm_demux4_if bus();

  tdm_demux4 #(.SYNC_LOSS_LIMIT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic dv, logic fs, logic d, logic [3:0] o,
                              logic fv, logic se, logic lk, logic [1:0] sl);
    vec_t v;
    v.dv = dv; v.fs = fs; v.d = d; v.out = o;
    v.fv = fv; v.se = se; v.lk = lk; v.slot = sl;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input vec_t v);
    logic [3:0] got;
    got = {bus.out3, bus.out2, bus.out1, bus.out0};
    n_vec++;
    if (got !== v.out || bus.frame_valid !== v.fv || bus.sync_err !== v.se ||
        bus.locked !== v.lk || bus.slot !== v.slot) begin
      n_bad++;
      $display("FAIL %s %0d: got out=%b fv=%b se=%b lk=%b slot=%0d, want out=%b fv=%b se=%b lk=%b slot=%0d",
               name, idx, got, bus.frame_valid, bus.sync_err, bus.locked, bus.slot,
               v.out, v.fv, v.se, v.lk, v.slot);
    end
  endtask

  task automatic apply(input string name, input int idx, input vec_t v);
    @(negedge clk);
    bus.din_valid  = v.dv;
    bus.frame_sync = v.fs;
    bus.din        = v.d;
    @(posedge clk);
    #1;
    check(name, idx, v);
  endtask

  initial begin
    vec_t post[$];
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    bus.din        = 1'b0;

    // no sync yet: beats discarded
    repeat (3) tbl.push_back(mk(1,0,1, 4'b0000, 0,0,0, 2'd0));
    // two aligned frames: 1,0,x,1 then 0,1,1,0
    tbl.push_back(mk(1,1,1,    4'b0000, 0,0,1, 2'd1));
    tbl.push_back(mk(1,0,0,    4'b0000, 0,0,1, 2'd2));
    tbl.push_back(mk(1,0,1'bx, 4'b0000, 0,0,1, 2'd3));
    tbl.push_back(mk(1,0,1,    4'b1x01, 1,0,1, 2'd0));
    tbl.push_back(mk(1,1,0,    4'b1x01, 0,0,1, 2'd1));
    tbl.push_back(mk(1,0,1,    4'b1x01, 0,0,1, 2'd2));
    tbl.push_back(mk(1,0,1,    4'b1x01, 0,0,1, 2'd3));
    tbl.push_back(mk(1,0,0,    4'b0110, 1,0,1, 2'd0));
    // sync on slot 2 restarts the frame
    tbl.push_back(mk(1,1,1, 4'b0110, 0,0,1, 2'd1));
    tbl.push_back(mk(1,0,0, 4'b0110, 0,0,1, 2'd2));
    tbl.push_back(mk(1,1,1, 4'b0110, 0,1,1, 2'd1));
    tbl.push_back(mk(1,0,1, 4'b0110, 0,0,1, 2'd2));
    tbl.push_back(mk(1,0,0, 4'b0110, 0,0,1, 2'd3));
    tbl.push_back(mk(1,0,0, 4'b0011, 1,0,1, 2'd0));
    // valid gap of 3 cycles between slots 1 and 2
    tbl.push_back(mk(1,1,0, 4'b0011, 0,0,1, 2'd1));
    tbl.push_back(mk(1,0,1, 4'b0011, 0,0,1, 2'd2));
    repeat (3) tbl.push_back(mk(0,1,1, 4'b0011, 0,0,1, 2'd2));
    tbl.push_back(mk(1,0,1, 4'b0011, 0,0,1, 2'd3));
    tbl.push_back(mk(1,0,1, 4'b1110, 1,0,1, 2'd0));
    // sync held low: two frames delivered, third slot-0 beat drops lock
    tbl.push_back(mk(1,0,1, 4'b1110, 0,0,1, 2'd1));
    tbl.push_back(mk(1,0,0, 4'b1110, 0,0,1, 2'd2));
    tbl.push_back(mk(1,0,0, 4'b1110, 0,0,1, 2'd3));
    tbl.push_back(mk(1,0,0, 4'b0001, 1,0,1, 2'd0));
    tbl.push_back(mk(1,0,0, 4'b0001, 0,0,1, 2'd1));
    tbl.push_back(mk(1,0,0, 4'b0001, 0,0,1, 2'd2));
    tbl.push_back(mk(1,0,1, 4'b0001, 0,0,1, 2'd3));
    tbl.push_back(mk(1,0,1, 4'b1100, 1,0,1, 2'd0));
    tbl.push_back(mk(1,0,1, 4'b1100, 0,0,0, 2'd0));
    repeat (2) tbl.push_back(mk(1,0,1, 4'b1100, 0,0,0, 2'd0));

    repeat (2) @(posedge clk);
    #1;
    check("reset", 0, mk(0,0,0, 4'b0000, 0,0,0, 2'd0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply("vec", i, tbl[i]);

    // reset pulsed after slot 2 of a frame
    apply("midrst", 0, mk(1,1,1, 4'b1100, 0,0,1, 2'd1));
    apply("midrst", 1, mk(1,0,1, 4'b1100, 0,0,1, 2'd2));
    apply("midrst", 2, mk(1,0,1, 4'b1100, 0,0,1, 2'd3));
    @(negedge clk);
    bus.din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst", 0, mk(0,0,0, 4'b0000, 0,0,0, 2'd0));
    @(negedge clk);
    rst_n = 1'b1;

    post.push_back(mk(1,0,1, 4'b0000, 0,0,0, 2'd0));
    post.push_back(mk(1,1,1, 4'b0000, 0,0,1, 2'd1));
    post.push_back(mk(1,0,0, 4'b0000, 0,0,1, 2'd2));
    post.push_back(mk(1,0,1, 4'b0000, 0,0,1, 2'd3));
    post.push_back(mk(1,0,0, 4'b0101, 1,0,1, 2'd0));
    for (int i = 0; i < post.size(); i++) apply("postrst", i, post[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer: the receive-side counterpart to the 4-to-1 select multiplexer. It takes a 1-bit serial stream in which four channels occupy consecutive slots (slot 0..3, marked by a frame sync on slot 0) and reassembles each frame into four registered channel outputs. Slot tracking and frame lock are handled by a small state machine. It sits downstream of a mux-based serializer and feeds the per-channel consumer logic and the channel comparison checker.

## Interface
- `SYNC_LOSS_LIMIT`, default 3: number of consecutive slot-0 beats without `frame_sync` that drops lock; legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `din`  in  1  serial data bit. 4-state values (x/z) are carried through unchanged.
- `din_valid`  in  1  `din` and `frame_sync` are sampled only on edges where this is 1.
- `frame_sync`  in  1  marks the beat carrying slot 0.
- `out0`..`out3`  out  1 each  channel outputs, registered; hold their value between frames.
- `frame_valid`  out  1  one-cycle pulse; `out0..3` are updated together in this cycle.
- `slot`  out  2  index of the next expected slot.
- `locked`  out  1  1 in the LOCKED state.
- `sync_err`  out  1  one-cycle pulse when `frame_sync` arrives on a nonzero slot.

## Operation
- Reset (`rst_n` = 0, asynchronous):
  - state is HUNT;
  - `slot`, `out0..3`, `frame_valid`, `sync_err`, `locked` and the miss counter are all 0;
  - the shadow registers are 0.
- The beat rules below apply only on edges with `din_valid` = 1. When `din_valid` = 0, state, `slot` and the shadow registers hold, and the pulse outputs go to 0.
- HUNT:
  - A beat with `frame_sync` = 0 is discarded.
  - A beat with `frame_sync` = 1 stores `din` in shadow0, sets `slot` = 1, clears the miss counter, and moves to LOCKED.
- LOCKED, beat on slot 0:
  - Store `din` in shadow0 and set `slot` = 1.
  - If `frame_sync` = 1, clear the miss counter.
  - If `frame_sync` = 0, increment the miss counter. When it reaches `SYNC_LOSS_LIMIT`, move to HUNT, set `slot` = 0 and clear the counter. The beat is discarded and no frame is emitted from it.
- LOCKED, beat on slot 1 or 2 with `frame_sync` = 0: store `din` in shadow[slot] and increment `slot`.
- LOCKED, beat on slot 3 with `frame_sync` = 0:
  - load `out0..2` from shadow0..2 and `out3` from `din`, all on the same edge;
  - assert `frame_valid` for one cycle;
  - set `slot` = 0 (wrap).
- LOCKED, beat on slot 1, 2 or 3 with `frame_sync` = 1 (misaligned sync):
  - pulse `sync_err`;
  - discard the partial frame, so `out0..3` and `frame_valid` are unchanged;
  - treat the beat as slot 0: store it in shadow0, set `slot` = 1, clear the miss counter, stay LOCKED.
- `locked` is a registered copy of the state, so it changes on the same edge as the state transition.
- Reset mid-frame drops the partial frame. After release, `out0..3` stay 0 until a full frame is received.

## Timing
- Latency: `out0..3` and `frame_valid` change on the rising edge that samples the slot-3 beat. They are visible one clock after that beat is presented.
- Minimum frame period is 4 clocks, with `din_valid` held at 1. Back-to-back frames give `frame_valid` every 4th cycle.
- Gaps with `din_valid` = 0 inside a frame are allowed and do not affect slot counting.
- `sync_err` is asserted in the cycle after the offending beat, for exactly one cycle.
- `frame_valid` and `sync_err` are never high in the same cycle.
- No combinational path from any input to any output.

## Test plan
- Reset, then 2 frames with `frame_sync` on slot 0, data 1,0,x,1 then 0,1,1,0 → `locked` = 1 after the first beat; `frame_valid` pulses on cycles 4 and 8; outputs are 1,0,x,1 then 0,1,1,0.
- Data beats before any `frame_sync` (din = 1,1,1) → `out0..3` stay 0, `locked` = 0, no `frame_valid`.
- Locked; `frame_sync` on slot 2 → `sync_err` pulses once; the previous outputs hold; the next 4 beats 1,1,0,0 give `frame_valid` with outputs 1,1,0,0.
- Locked, `SYNC_LOSS_LIMIT` = 3; frames with `frame_sync` held at 0 → frames 1 and 2 are delivered; on the third slot-0 beat `locked` falls, `slot` = 0, and no third `frame_valid` occurs.
- One frame with `din_valid` = 0 for 3 cycles between slots 1 and 2 → the frame is still delivered correctly; `frame_valid` is delayed by 3 cycles.
- `rst_n` pulsed low after slot 2 of a frame → all outputs return to 0 immediately; no `frame_valid` until a new frame that starts with sync completes.
